// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing the six HEX digits among NUM_REQ requesters.
// Grants are held for whole HOLD_CYCLES periods; the owner's value is decoded active-low.
module hex_display_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         REQ,
    input  logic [24*NUM_REQ-1:0]      DATA,
    output logic [NUM_REQ-1:0]         GNT,
    output logic                       ACTIVE,
    output logic [$clog2(NUM_REQ)-1:0] OWNER,
    output logic [6:0]                 HEX0,
    output logic [6:0]                 HEX1,
    output logic [6:0]                 HEX2,
    output logic [6:0]                 HEX3,
    output logic [6:0]                 HEX4,
    output logic [6:0]                 HEX5
);
    localparam int          OW = $clog2(NUM_REQ);
    localparam int          CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned NR = NUM_REQ;

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t        r_state, w_state_nxt;
    logic [OW-1:0] r_owner, w_owner_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic [23:0]   r_data,  w_data_nxt;

    logic          w_found;
    logic [OW-1:0] w_win;
    logic [23:0]   w_win_data;
    logic [23:0]   w_own_data;
    logic          w_own_req;
    logic          w_hold_end;

    // Search OWNER+1 .. OWNER+NUM_REQ; the owner itself comes last, so the same
    // winner serves both the IDLE start and the hold-end handover/extension.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_owner;
        for (int unsigned off = 1; off <= NR; off++) begin
            int unsigned idx;
            idx = (32'(r_owner) + off) % NR;
            if (!w_found && REQ[idx]) begin
                w_found = 1'b1;
                w_win   = OW'(idx);
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        w_own_data = '0;
        w_own_req  = 1'b0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (OW'(i) == w_win) begin
                w_win_data = DATA[24*i +: 24];
            end
            if (OW'(i) == r_owner) begin
                w_own_data = DATA[24*i +: 24];
                w_own_req  = REQ[i];
            end
        end
    end

    assign w_hold_end = (r_cnt == CW'(HOLD_CYCLES - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_HOLD;
                    w_owner_nxt = w_win;
                    w_cnt_nxt   = '0;
                    w_data_nxt  = w_win_data;
                end
            end
            S_HOLD: begin
                if (w_hold_end) begin
                    if (w_found) begin
                        w_owner_nxt = w_win;
                        w_cnt_nxt   = '0;
                        w_data_nxt  = w_win_data;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (w_own_req) begin
                        w_data_nxt = w_own_data;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_owner <= OW'(NUM_REQ - 1);
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        ACTIVE = (r_state == S_HOLD);
        OWNER  = r_owner;
        for (int unsigned i = 0; i < NR; i++) begin
            GNT[i] = ACTIVE && (OW'(i) == r_owner);
        end
        HEX0 = ACTIVE ? seg7(r_data[3:0])   : 7'h7F;
        HEX1 = ACTIVE ? seg7(r_data[7:4])   : 7'h7F;
        HEX2 = ACTIVE ? seg7(r_data[11:8])  : 7'h7F;
        HEX3 = ACTIVE ? seg7(r_data[15:12]) : 7'h7F;
        HEX4 = ACTIVE ? seg7(r_data[19:16]) : 7'h7F;
        HEX5 = ACTIVE ? seg7(r_data[23:20]) : 7'h7F;
    end
endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench for hex_display_arbiter with NUM_REQ=4, HOLD_CYCLES=4.
// Stimulus queues the expected post-edge state; a monitor pops one entry per edge.
module tb_hex_display_arbiter;
    logic        CLK;
    logic        RST;
    logic [3:0]  REQ;
    logic [95:0] DATA;
    logic [3:0]  GNT;
    logic        ACTIVE;
    logic [1:0]  OWNER;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    hex_display_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .DATA(DATA),
        .GNT(GNT), .ACTIVE(ACTIVE), .OWNER(OWNER),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
        .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    typedef struct {
        logic [3:0]  gnt;
        logic [1:0]  own;
        logic [23:0] data;
        string       tag;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [95:0] dv;
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    // Monitor: compares the DUT state just after each rising edge
    initial begin
        exp_t        e;
        logic [41:0] exp_hex, got_hex;
        logic        exp_act;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e       = q.pop_front();
                exp_act = (e.gnt != 4'b0000);
                for (int k = 0; k < 6; k++) begin
                    exp_hex[7*k +: 7] = exp_act ? seg_tab[e.data[4*k +: 4]] : 7'h7F;
                end
                got_hex = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
                n_tests++;
                if (GNT !== e.gnt || ACTIVE !== exp_act || OWNER !== e.own || got_hex !== exp_hex) begin
                    n_fail++;
                    $display("FAIL %s: got gnt=%b act=%b own=%0d hex=%h, expected gnt=%b act=%b own=%0d hex=%h",
                             e.tag, GNT, ACTIVE, OWNER, got_hex, e.gnt, exp_act, e.own, exp_hex);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] egnt,
                        input logic [1:0] eown, input logic [23:0] edata, input string tag);
        exp_t e;
        @(negedge CLK);
        RST  = rst;
        REQ  = req;
        DATA = dv;
        e.gnt = egnt; e.own = eown; e.data = edata; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic rst_step();
        step(1'b1, 4'b0000, 4'b0000, 2'd3, 24'h0, "reset");
    endtask

    initial begin
        RST  = 1'b1;
        REQ  = '0;
        DATA = '0;
        dv   = '0;

        // 1: reset state
        rst_step();
        step(1'b0, 4'b0000, 4'b0000, 2'd3, 24'h0, "idle_after_reset");

        // 2: single requester, held across boundaries, live data update
        dv[23:0] = 24'h012345;
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0001, 4'b0001, 2'd0, 24'h012345, "single_hold");
        dv[23:0] = 24'hFEDCBA;
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0001, 4'b0001, 2'd0, 24'hFEDCBA, "live_update");
        rst_step();

        // 3: all request, round-robin 0,1,2,3,0 with 4-cycle slots
        dv = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
        for (int g = 0; g < 20; g++) begin
            int o;
            o = (g / 4) % 4;
            step(1'b0, 4'b1111, 4'(1 << o), 2'(o), dv[24*o +: 24], "round_robin");
        end
        rst_step();

        // 4: owner drops request, value frozen, then release to idle
        dv = '0;
        dv[23:0] = 24'hABCDEF;
        step(1'b0, 4'b0001, 4'b0001, 2'd0, 24'hABCDEF, "freeze_grant");
        dv[23:0] = 24'h000000;
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 4'b0001, 2'd0, 24'hABCDEF, "freeze_hold");
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 24'h0, "release_idle");
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 24'h0, "stay_idle");
        dv = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
        step(1'b0, 4'b1111, 4'b0010, 2'd1, 24'h222222, "rr_after_idle");
        rst_step();

        // 5: reset mid-hold, then regrant
        dv = '0;
        dv[71:48] = 24'hC0FFEE;
        step(1'b0, 4'b0100, 4'b0100, 2'd2, 24'hC0FFEE, "grant2");
        step(1'b0, 4'b0100, 4'b0100, 2'd2, 24'hC0FFEE, "grant2_c1");
        step(1'b1, 4'b0100, 4'b0000, 2'd3, 24'h0, "mid_hold_reset");
        step(1'b0, 4'b0100, 4'b0100, 2'd2, 24'hC0FFEE, "regrant2");
        rst_step();

        // 6: late request from 3 takes over exactly at hold end
        dv = '0;
        dv[23:0]  = 24'h123456;
        dv[95:72] = 24'hFEDCBA;
        step(1'b0, 4'b0001, 4'b0001, 2'd0, 24'h123456, "own0_c0");
        step(1'b0, 4'b0001, 4'b0001, 2'd0, 24'h123456, "own0_c1");
        step(1'b0, 4'b1001, 4'b0001, 2'd0, 24'h123456, "own0_c2");
        step(1'b0, 4'b1001, 4'b0001, 2'd0, 24'h123456, "own0_c3");
        step(1'b0, 4'b1001, 4'b1000, 2'd3, 24'hFEDCBA, "handover3");
        step(1'b0, 4'b1000, 4'b1000, 2'd3, 24'hFEDCBA, "own3_c1");

        @(negedge CLK);
        @(negedge CLK);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
